// File: rtl/sync_fifo_pkg.sv
// Shared constants for the single-clock FIFO.
//   FIFO_DATA_W / FIFO_ADDR_W / FIFO_DEPTH : default parameter values
//   cnt_width()                            : occupancy counter width for a given depth
package sync_fifo_pkg;

    localparam int unsigned FIFO_DATA_W = 8;
    localparam int unsigned FIFO_ADDR_W = 4;
    localparam int unsigned FIFO_DEPTH  = 8;

    // Counter must hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W storage for sync_fifo: one synchronous write port and one
// registered read port with read enable. Only the read register is reset;
// the storage array keeps its contents across reset.
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset (clears rd_data only)
//   wr_en    in   write strobe
//   wr_addr  in   write address (always < DEPTH)
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data loads mem[rd_addr] when set
//   rd_addr  in   read address (always < DEPTH)
//   rd_data  out  registered read data, holds when rd_en is low
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned ADDR_W = FIFO_ADDR_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Index width sized to the array; pointer upper bits are always zero.
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[IDX_W'(wr_addr)] <= wr_data;
        end
    end

    // Registered read port; a same-cycle write to the same slot is not seen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[IDX_W'(rd_addr)];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with registered read data and exposed pointers.
//   CLK      in   rising-edge clock
//   RST      in   synchronous active-low reset
//   wr_en    in   write request
//   rd_en    in   read request
//   data_in  in   write data
//   wr_adr   out  next slot to write
//   rd_adr   out  next slot to read
//   empty    out  occupancy == 0 (decoded from registered count)
//   full     out  occupancy == DEPTH (decoded from registered count)
//   data_out out  registered read data, holds when no read is accepted
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned ADDR_W = FIFO_ADDR_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] wr_adr,
    output logic [ADDR_W-1:0] rd_adr,
    output logic              empty,
    output logic              full,
    output logic [DATA_W-1:0] data_out
);

    localparam int unsigned       CNT_W    = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [ADDR_W-1:0] wr_adr_nxt;
    logic [ADDR_W-1:0] rd_adr_nxt;
    logic              wr_accept;
    logic              rd_accept;
    logic              mem_we;

    // Flags are pure decodes of the registered occupancy.
    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // Accept decisions and next pointer/count values.
    always_comb begin
        wr_accept  = 1'b0;
        rd_accept  = 1'b0;
        wr_adr_nxt = wr_adr;
        rd_adr_nxt = rd_adr;
        count_nxt  = count;

        // A read frees a slot this cycle, so a full FIFO still takes a write
        // when paired with a read. A read never passes an empty FIFO, even
        // with a simultaneous write.
        wr_accept = wr_en && (!full || rd_en);
        rd_accept = rd_en && !empty;

        if (wr_accept) begin
            wr_adr_nxt = (wr_adr == PTR_LAST) ? '0 : wr_adr + ADDR_W'(1);
        end
        if (rd_accept) begin
            rd_adr_nxt = (rd_adr == PTR_LAST) ? '0 : rd_adr + ADDR_W'(1);
        end

        unique case ({wr_accept, rd_accept})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_adr <= '0;
            rd_adr <= '0;
            count  <= '0;
        end else begin
            wr_adr <= wr_adr_nxt;
            rd_adr <= rd_adr_nxt;
            count  <= count_nxt;
        end
    end

    // Reset also suppresses a write requested in the same cycle.
    assign mem_we = wr_accept && RST;

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (CLK),
        .rst_n   (RST),
        .wr_en   (mem_we),
        .wr_addr (wr_adr),
        .wr_data (data_in),
        .rd_en   (rd_accept),
        .rd_addr (rd_adr),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// queue-based reference model.
module tb_sync_fifo;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] wr_adr;
    logic [ADDR_W-1:0] rd_adr;
    logic              empty;
    logic              full;
    logic [DATA_W-1:0] data_out;

    int checks = 0;
    int errors = 0;

    sync_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .wr_adr   (wr_adr),
        .rd_adr   (rd_adr),
        .empty    (empty),
        .full     (full),
        .data_out (data_out)
    );

    always #5 CLK = ~CLK;

    // Reference model: contents as a queue, pointers as modular counters.
    int q[$];
    int m_wr    = 0;
    int m_rd    = 0;
    int m_dout  = 0;
    bit m_valid = 1'b0;

    always @(posedge CLK) begin : model
        bit wa;
        bit ra;
        int sz;
        if (!RST) begin
            q.delete();
            m_wr    = 0;
            m_rd    = 0;
            m_dout  = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            sz = q.size();
            wa = wr_en && (sz < DEPTH || rd_en);
            ra = rd_en && (sz > 0);
            if (ra) begin
                m_dout = q.pop_front();
                m_rd   = (m_rd + 1) % DEPTH;
            end
            if (wa) begin
                q.push_back(int'(data_in));
                m_wr = (m_wr + 1) % DEPTH;
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (m_valid) begin
            cmp("m_empty",    int'(empty),    int'(q.size() == 0));
            cmp("m_full",     int'(full),     int'(q.size() == DEPTH));
            cmp("m_wr_adr",   int'(wr_adr),   m_wr);
            cmp("m_rd_adr",   int'(rd_adr),   m_rd);
            cmp("m_data_out", int'(data_out), m_dout);
        end
    end

    // Drive one cycle of inputs at the falling edge, return at the next one.
    task automatic cyc(input logic rst, input logic w, input logic r, input logic [DATA_W-1:0] d);
        RST     = rst;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int bias_w;
        int bias_r;
        RST = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        @(negedge CLK);

        // Reset held two cycles.
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        cmp("rst_empty",  int'(empty),    1);
        cmp("rst_full",   int'(full),     0);
        cmp("rst_wr_adr", int'(wr_adr),   0);
        cmp("rst_rd_adr", int'(rd_adr),   0);
        cmp("rst_dout",   int'(data_out), 0);

        // Fill to full, then an extra write is dropped.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'(97 + i));
            cmp("fill_wr_adr", int'(wr_adr), (i + 1) % 8);
            cmp("fill_empty",  int'(empty),  0);
            cmp("fill_full",   int'(full),   int'(i == 7));
        end
        cyc(1'b1, 1'b1, 1'b0, 8'd105);
        cmp("drop_wr_adr", int'(wr_adr), 0);
        cmp("drop_full",   int'(full),   1);
        cmp("model_size",  q.size(),     8);

        // Drain in order.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 8'd0);
            cmp("drain_dout",   int'(data_out), 97 + i);
            cmp("model_dout",   m_dout,         97 + i);
            cmp("drain_full",   int'(full),     0);
            cmp("drain_empty",  int'(empty),    int'(i == 7));
            cmp("drain_rd_adr", int'(rd_adr),   (i + 1) % 8);
        end

        // Pause mid-drain.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 8'(97 + i));
        cyc(1'b1, 1'b0, 1'b1, 8'd0);
        cyc(1'b1, 1'b0, 1'b1, 8'd0);
        cmp("pause_dout0",  int'(data_out), 98);
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        cmp("pause_dout1",  int'(data_out), 98);
        cmp("pause_rd_adr", int'(rd_adr),   2);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 8'd0);
            cmp("resume_dout", int'(data_out), 99 + i);
        end
        cmp("resume_empty", int'(empty), 1);

        // Read while empty is ignored.
        cyc(1'b1, 1'b0, 1'b1, 8'd0);
        cmp("rdempty_dout",   int'(data_out), 104);
        cmp("rdempty_rd_adr", int'(rd_adr),   0);
        cmp("rdempty_empty",  int'(empty),    1);

        // Read+write while full.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 8'(16 + i));
        cyc(1'b1, 1'b1, 1'b1, 8'h30);
        cmp("rwfull_full", int'(full),     1);
        cmp("rwfull_dout", int'(data_out), 16);
        cmp("rwfull_size", q.size(),       8);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 8'd0);
            cmp("rwfull_order", int'(data_out), 17 + i);
        end
        cyc(1'b1, 1'b0, 1'b1, 8'd0);
        cmp("rwfull_last", int'(data_out), 8'h30);

        // Read+write while empty: only the write lands.
        cyc(1'b1, 1'b1, 1'b1, 8'h44);
        cmp("rwempty_empty", int'(empty),    0);
        cmp("rwempty_dout",  int'(data_out), 8'h30);
        cmp("rwempty_size",  q.size(),       1);
        cyc(1'b1, 1'b0, 1'b1, 8'd0);
        cmp("rwempty_read",  int'(data_out), 8'h44);

        // Reset with five words stored, with a write requested alongside.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 8'(200 + i));
        cyc(1'b0, 1'b1, 1'b0, 8'h77);
        cmp("mrst_empty",  int'(empty),    1);
        cmp("mrst_wr_adr", int'(wr_adr),   0);
        cmp("mrst_rd_adr", int'(rd_adr),   0);
        cmp("mrst_dout",   int'(data_out), 0);
        cyc(1'b1, 1'b1, 1'b0, 8'h5A);
        cyc(1'b1, 1'b0, 1'b1, 8'd0);
        cmp("mrst_read",   int'(data_out), 8'h5A);
        cmp("mrst_empty2", int'(empty),    1);

        // Randomized traffic with shifting write/read bias and rare resets.
        bias_w = 50;
        bias_r = 50;
        for (int n = 0; n < 2000; n++) begin
            if (n % 200 == 0) begin
                bias_w = $urandom_range(10, 90);
                bias_r = $urandom_range(10, 90);
            end
            cyc(($urandom_range(0, 149) != 0),
                ($urandom_range(0, 99) < bias_w),
                ($urandom_range(0, 99) < bias_r),
                DATA_W'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
